// File: rtl/dtw_core_feeder.sv
// Front end for the DTW core: splits one sample stream into squiggle load and
// reference stream phases, waits for core completion and returns one result per search.
module dtw_core_feeder #(
  parameter int WORD_LEN     = 16,
  parameter int SQG_LEN      = 250,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         cfg_ref_len,
  output logic                busy,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_LEN-1:0] s_data,
  output logic                core_load_squiggle,
  output logic [WORD_LEN-1:0] core_squiggle_word,
  output logic                core_running,
  output logic [WORD_LEN-1:0] core_reference_word,
  output logic [31:0]         core_reference_len,
  input  logic [WORD_LEN-1:0] core_best_score,
  input  logic [31:0]         core_best_position,
  input  logic                core_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WORD_LEN-1:0] res_score,
  output logic [31:0]         res_position,
  output logic                err
);

  localparam int SQW = $clog2(SQG_LEN + 1);
  localparam int TOW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [SQW-1:0] SQG_LAST = SQW'(SQG_LEN - 1);
  localparam logic [TOW-1:0] TMO_LAST = TOW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Q,
    S_SETTLE,
    S_STREAM_R,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [SQW-1:0]      r_sqg_cnt;
  logic [31:0]         r_ref_cnt;
  logic [31:0]         r_ref_len;
  logic [TOW-1:0]      r_tmo_cnt;
  logic                r_settle_cnt;
  logic                r_load;
  logic [WORD_LEN-1:0] r_sqg_word;
  logic                r_run;
  logic [WORD_LEN-1:0] r_ref_word;
  logic [WORD_LEN-1:0] r_res_score;
  logic [31:0]         r_res_pos;
  logic                r_err;

  logic                w_s_ready;
  logic                w_start_ok;
  logic                w_start_zero;
  logic                w_sqg_beat;
  logic                w_ref_beat;
  logic                w_capture;
  logic                w_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_ready    = 1'b0;
    w_start_ok   = 1'b0;
    w_start_zero = 1'b0;
    w_sqg_beat   = 1'b0;
    w_ref_beat   = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ref_len != 32'd0) begin
            w_start_ok   = 1'b1;
            w_state_next = S_LOAD_Q;
          end else begin
            w_start_zero = 1'b1;
          end
        end
      end
      S_LOAD_Q: begin
        w_s_ready  = 1'b1;
        w_sqg_beat = s_valid;
        if (s_valid && (r_sqg_cnt == SQG_LAST)) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt) begin
          w_state_next = S_STREAM_R;
        end
      end
      S_STREAM_R: begin
        w_s_ready  = 1'b1;
        w_ref_beat = s_valid;
        // Leaving on the final beat keeps s_ready low once the count reaches the length.
        if (s_valid && (r_ref_cnt == (r_ref_len - 32'd1))) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (core_done) begin
          w_capture    = 1'b1;
          w_state_next = S_RESULT;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sqg_cnt    <= '0;
      r_ref_cnt    <= '0;
      r_ref_len    <= '0;
      r_tmo_cnt    <= '0;
      r_settle_cnt <= 1'b0;
      r_load       <= 1'b0;
      r_sqg_word   <= '0;
      r_run        <= 1'b0;
      r_ref_word   <= '0;
      r_res_score  <= '0;
      r_res_pos    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_run  <= 1'b0;
      r_err  <= w_start_zero | w_timeout;

      if (w_start_ok) begin
        r_ref_len    <= cfg_ref_len;
        r_sqg_cnt    <= '0;
        r_ref_cnt    <= '0;
        r_tmo_cnt    <= '0;
        r_settle_cnt <= 1'b0;
      end

      if (w_sqg_beat) begin
        r_sqg_word <= s_data;
        r_load     <= 1'b1;
        r_sqg_cnt  <= r_sqg_cnt + 1'b1;
      end

      if (r_state == S_SETTLE) begin
        r_settle_cnt <= ~r_settle_cnt;
      end

      if (w_ref_beat) begin
        r_ref_word <= s_data;
        r_run      <= 1'b1;
        r_ref_cnt  <= r_ref_cnt + 32'd1;
      end

      // Timeout window opens on the cycle after the last reference beat.
      if (r_state == S_WAIT_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_capture) begin
        r_res_score <= core_best_score;
        r_res_pos   <= core_best_position;
      end
    end
  end

  assign busy                = (r_state != S_IDLE);
  assign s_ready             = w_s_ready;
  assign core_load_squiggle  = r_load;
  assign core_squiggle_word  = r_sqg_word;
  assign core_running        = r_run;
  assign core_reference_word = r_ref_word;
  assign core_reference_len  = r_ref_len;
  assign res_valid           = (r_state == S_RESULT);
  assign res_score           = r_res_score;
  assign res_position        = r_res_pos;
  assign err                 = r_err;

endmodule

// File: tb/tb_dtw_core_feeder.sv
// Bench for dtw_core_feeder: per-cycle model comparison of every output plus
// hand-computed checks for each directed search scenario.
module tb_dtw_core_feeder;

  localparam int SQG = 5;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_ref_len = '0;
  logic        busy;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        core_load_squiggle;
  logic [15:0] core_squiggle_word;
  logic        core_running;
  logic [15:0] core_reference_word;
  logic [31:0] core_reference_len;
  logic [15:0] core_best_score = '0;
  logic [31:0] core_best_position = '0;
  logic        core_done = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_score;
  logic [31:0] res_position;
  logic        err;

  dtw_core_feeder #(.WORD_LEN(16), .SQG_LEN(SQG), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ref_len(cfg_ref_len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .core_load_squiggle(core_load_squiggle), .core_squiggle_word(core_squiggle_word),
    .core_running(core_running), .core_reference_word(core_reference_word),
    .core_reference_len(core_reference_len), .core_best_score(core_best_score),
    .core_best_position(core_best_position), .core_done(core_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
    .res_position(res_position), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what each output must be this cycle, advanced from sampled inputs.
  bit          mon_en = 1'b0;
  bit          m_active, m_waiting, m_result;
  int          m_sqg_left, m_settle_left, m_wait_cnt;
  longint      m_ref_left;
  bit          e_load, e_run, e_err;
  bit [15:0]   e_sqw, e_refw, e_score;
  bit [31:0]   e_len, e_pos;

  int          cyc_no = 0;
  int          n_load = 0, n_run = 0, n_err = 0, n_resv = 0;
  int          last_load_cyc = 0, first_run_cyc = 0, last_run_cyc = 0, err_cyc = 0;
  bit          run_seen = 1'b0;
  logic [15:0] obs_ref[$];

  always @(negedge clk) begin
    bit e_busy, e_ready, e_resv;
    cyc_no++;
    e_busy  = m_active;
    e_ready = m_active && (m_sqg_left > 0 || (m_settle_left == 0 && m_ref_left > 0));
    e_resv  = m_result;
    if (mon_en) begin
      check("busy", busy, e_busy);
      check("s_ready", s_ready, e_ready);
      check("load", core_load_squiggle, e_load);
      check("sqg_word", core_squiggle_word, e_sqw);
      check("running", core_running, e_run);
      check("ref_word", core_reference_word, e_refw);
      check("ref_len", core_reference_len, e_len);
      check("res_valid", res_valid, e_resv);
      check("res_score", res_score, e_score);
      check("res_pos", res_position, e_pos);
      check("err", err, e_err);
      if (core_load_squiggle) begin
        n_load++;
        last_load_cyc = cyc_no;
        run_seen = 1'b0;
      end
      if (core_running) begin
        n_run++;
        obs_ref.push_back(core_reference_word);
        if (!run_seen) begin
          first_run_cyc = cyc_no;
          run_seen = 1'b1;
        end
        last_run_cyc = cyc_no;
      end
      if (err) begin
        n_err++;
        err_cyc = cyc_no;
      end
      if (res_valid) n_resv++;
    end
    if (!rst) begin
      m_active = 0; m_waiting = 0; m_result = 0;
      m_sqg_left = 0; m_settle_left = 0; m_ref_left = 0; m_wait_cnt = 0;
      e_load = 0; e_run = 0; e_err = 0; e_sqw = 0; e_refw = 0;
      e_len = 0; e_score = 0; e_pos = 0;
    end else begin
      e_load = 0; e_run = 0; e_err = 0;
      if (!m_active) begin
        if (start) begin
          if (cfg_ref_len == 0) e_err = 1;
          else begin
            m_active = 1; m_sqg_left = SQG; m_settle_left = 2;
            m_ref_left = cfg_ref_len; e_len = cfg_ref_len; m_wait_cnt = 0;
          end
        end
      end else if (m_sqg_left > 0) begin
        if (s_valid) begin e_load = 1; e_sqw = s_data; m_sqg_left--; end
      end else if (m_settle_left > 0) begin
        m_settle_left--;
      end else if (m_ref_left > 0) begin
        if (s_valid) begin
          e_run = 1; e_refw = s_data; m_ref_left--;
          if (m_ref_left == 0) m_waiting = 1;
        end
      end else if (m_waiting) begin
        if (core_done) begin
          e_score = core_best_score; e_pos = core_best_position;
          m_waiting = 0; m_result = 1;
        end else begin
          m_wait_cnt++;
          if (m_wait_cnt == TMO) begin e_err = 1; m_waiting = 0; m_active = 0; end
        end
      end else if (m_result) begin
        if (res_ready) begin m_result = 0; m_active = 0; end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_search(input int len);
    cfg_ref_len = len;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic stream_words(input int base, input int total, input int bubble,
                              input bit noise, input int abort_idx, output bit aborted);
    int idx = 0;
    int guard = 0;
    bit hs;
    aborted = 1'b0;
    while (idx < total) begin
      if (guard >= 400) begin
        check("stream_budget", idx, total);
        break;
      end
      s_valid   = (bubble == 0) || ((guard % bubble) != bubble - 1);
      s_data    = 16'(base + idx);
      core_done = noise && (idx < SQG);
      if (idx == abort_idx) begin
        rst = 1'b0; s_valid = 1'b1; core_done = 1'b0;
        cyc();
        rst = 1'b1; s_valid = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      cyc();
      if (hs) idx++;
      guard++;
    end
    s_valid = 1'b0;
    core_done = 1'b0;
  endtask

  task automatic finish_core(input logic [15:0] score, input logic [31:0] pos);
    cyc(); cyc(); cyc();
    core_best_score = score;
    core_best_position = pos;
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
  endtask

  task automatic wait_res(input int bound);
    int k = 0;
    while (k < bound) begin
      @(negedge clk);
      if (res_valid) break;
      k++;
    end
    check("res_wait", res_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, r0, q0, e0, v0, k;
    bit ab;

    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_len", core_reference_len, 0);
    check("rst_res_valid", res_valid, 0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Contiguous search
    res_ready = 1'b1;
    l0 = n_load; r0 = n_run; q0 = obs_ref.size();
    start_search(25);
    stream_words(16'h1000, SQG + 25, 0, 1'b0, -1, ab);
    finish_core(16'h0123, 32'd17);
    wait_res(10);
    cyc(); cyc();
    check("t1_loads", n_load - l0, 5);
    check("t1_runs", n_run - r0, 25);
    check("t1_gap", first_run_cyc - last_load_cyc, 3);
    check("t1_contig", last_run_cyc - first_run_cyc, 24);
    check("t1_first_ref", obs_ref[q0], 16'h1005);
    check("t1_score", res_score, 16'h0123);
    check("t1_pos", res_position, 17);
    check("t1_idle", busy, 0);

    // Bubbles every 3rd cycle, stray core_done while loading
    l0 = n_load; r0 = n_run; q0 = obs_ref.size();
    start_search(25);
    stream_words(16'h2000, SQG + 25, 3, 1'b1, -1, ab);
    finish_core(16'h0456, 32'd3);
    wait_res(10);
    cyc(); cyc();
    check("t2_loads", n_load - l0, 5);
    check("t2_runs", n_run - r0, 25);
    for (int i = 0; i < 25; i++) begin
      if (q0 + i < obs_ref.size()) check("t2_order", obs_ref[q0 + i], 16'(16'h2005 + i));
      else check("t2_order_missing", obs_ref.size(), q0 + 25);
    end
    check("t2_score", res_score, 16'h0456);

    // Zero-length start
    e0 = n_err;
    start_search(0);
    check("t3_busy", busy, 0);
    check("t3_ready", s_ready, 0);
    cyc(); cyc();
    check("t3_err_count", n_err - e0, 1);
    check("t3_busy_after", busy, 0);

    // Result held off 10 cycles; starts ignored; cfg change after latch ignored
    res_ready = 1'b0;
    r0 = n_run;
    start_search(25);
    cfg_ref_len = 7;
    stream_words(16'h3000, SQG + 25, 0, 1'b0, -1, ab);
    v0 = n_resv;
    finish_core(16'h0789, 32'd100);
    wait_res(10);
    for (int i = 1; i < 10; i++) begin
      cyc();
      start = ((i % 4) == 1);
    end
    cyc();
    start = 1'b0;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    cyc();
    check("t4_resv_cycles", n_resv - v0, 11);
    check("t4_runs", n_run - r0, 25);
    check("t4_score", res_score, 16'h0789);
    check("t4_pos", res_position, 100);
    check("t4_len_kept", core_reference_len, 25);
    check("t4_idle", busy, 0);

    // Core never finishes
    res_ready = 1'b1;
    start_search(25);
    stream_words(16'h4000, SQG + 25, 0, 1'b0, -1, ab);
    v0 = n_resv; e0 = n_err;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (err) break;
      k++;
    end
    check("t5_err_seen", err, 1);
    cyc(); cyc();
    check("t5_delay", err_cyc - last_run_cyc, 16);
    check("t5_no_result", n_resv - v0, 0);
    check("t5_err_count", n_err - e0, 1);
    check("t5_idle", busy, 0);

    // Reset during reference beat 12, then a clean search
    r0 = n_run;
    start_search(25);
    stream_words(16'h5000, SQG + 25, 0, 1'b0, SQG + 11, ab);
    check("t6_aborted", ab, 1);
    check("t6_busy", busy, 0);
    check("t6_len", core_reference_len, 0);
    check("t6_score", res_score, 0);
    check("t6_running", core_running, 0);
    check("t6_ready", s_ready, 0);
    check("t6_runs_before", n_run - r0, 11);
    cyc();
    l0 = n_load; r0 = n_run;
    start_search(25);
    stream_words(16'h6000, SQG + 25, 0, 1'b0, -1, ab);
    finish_core(16'h0ABC, 32'd24);
    wait_res(10);
    cyc(); cyc();
    check("t6_loads", n_load - l0, 5);
    check("t6_runs", n_run - r0, 25);
    check("t6_res_score", res_score, 16'h0ABC);
    check("t6_res_pos", res_position, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
